// File: rtl/bitwise_logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Shared operation encodings and widths for the bitwise logic
//                unit and its interface.
//                Optional feature macro: LOGIC_XOR_EN (enables OP_XOR).
//  Revision    : 1.0  initial release
// ============================================================================
package logic_unit_pkg;

    // Width of the operation select field.
    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 2'b00,
        OP_OR    = 2'b01,
        OP_NOT_A = 2'b10,
        OP_XOR   = 2'b11
    } op_e;

endpackage : logic_unit_pkg
`default_nettype wire

// File: rtl/bitwise_logic_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_logic_unit_if
//  Description : Request/result bundle for bitwise_logic_unit.
//                master : drives in_valid/op/a/b, observes results.
//                slave  : the logic unit itself.
//                Signals: in_valid, op[OP_W], a[N], b[N] (request)
//                         res[N], out_valid, zero, all_ones, illegal_op (result)
//  Revision    : 1.0  initial release
// ============================================================================
interface bitwise_logic_unit_if
    import logic_unit_pkg::*;
#(
    parameter int N = 8
);

    logic            in_valid;
    logic [OP_W-1:0] op;
    logic [N-1:0]    a;
    logic [N-1:0]    b;

    logic [N-1:0]    res;
    logic            out_valid;
    logic            zero;
    logic            all_ones;
    logic            illegal_op;

    modport master (
        output in_valid, op, a, b,
        input  res, out_valid, zero, all_ones, illegal_op
    );

    modport slave (
        input  in_valid, op, a, b,
        output res, out_valid, zero, all_ones, illegal_op
    );

endinterface : bitwise_logic_unit_if
`default_nettype wire

// File: rtl/logic_gate_n.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_n
//  Description : Combinational N-bit gate bank. Produces every supported
//                bitwise function in parallel; selection happens upstream.
//                Ports: a, b (operands) -> and_o, or_o, not_o (= ~a),
//                       xor_o (only when LOGIC_XOR_EN is defined).
//  Revision    : 1.0  initial release
// ============================================================================
module logic_gate_n #(
    parameter int N = 8
) (
    input  wire logic [N-1:0] a,
    input  wire logic [N-1:0] b,
    output logic      [N-1:0] and_o,
    output logic      [N-1:0] or_o,
`ifdef LOGIC_XOR_EN
    output logic      [N-1:0] xor_o,
`endif
    output logic      [N-1:0] not_o
);

    assign and_o = a & b;
    assign or_o  = a | b;
    assign not_o = ~a;
`ifdef LOGIC_XOR_EN
    assign xor_o = a ^ b;
`endif

endmodule : logic_gate_n
`default_nettype wire

// File: rtl/bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bitwise_logic_unit
//  Description : Registered N-bit bitwise logic unit (AND / OR / NOT_A, and
//                XOR when LOGIC_XOR_EN is defined). One-cycle latency; result
//                and flags hold until the next accepted operation.
//                Ports: clk, rst (sync, active-high),
//                       bus (bitwise_logic_unit_if.slave): in_valid, op, a, b
//                       -> res, out_valid, zero, all_ones, illegal_op.
//                Optional feature macro: LOGIC_XOR_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module bitwise_logic_unit
    import logic_unit_pkg::*;
#(
    parameter int N = 8
) (
    input wire logic             clk,
    input wire logic             rst,
    bitwise_logic_unit_if.slave  bus
);

    logic [N-1:0] w_and;
    logic [N-1:0] w_or;
    logic [N-1:0] w_not;
`ifdef LOGIC_XOR_EN
    logic [N-1:0] w_xor;
`endif

    logic [N-1:0] w_res;
    logic         w_illegal;

    logic [N-1:0] r_res;
    logic         r_out_valid;
    logic         r_zero;
    logic         r_all_ones;
    logic         r_illegal_op;

    logic_gate_n #(
        .N     (N)
    ) u_gates (
        .a     (bus.a),
        .b     (bus.b),
        .and_o (w_and),
        .or_o  (w_or),
`ifdef LOGIC_XOR_EN
        .xor_o (w_xor),
`endif
        .not_o (w_not)
    );

    // Operation select. An unsupported op yields an all-zero result so the
    // flags stay self-consistent (zero=1) while illegal_op reports it.
    always_comb begin
        w_res     = '0;
        w_illegal = 1'b0;
        case (bus.op)
            OP_AND:   w_res = w_and;
            OP_OR:    w_res = w_or;
            OP_NOT_A: w_res = w_not;
`ifdef LOGIC_XOR_EN
            OP_XOR:   w_res = w_xor;
`else
            OP_XOR:   w_illegal = 1'b1;
`endif
            default:  w_illegal = 1'b1;
        endcase
    end

    // Result/flag registers load only on an accepted op, so operand values
    // (including X) are never sampled while in_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res        <= '0;
            r_out_valid  <= 1'b0;
            r_zero       <= 1'b1;
            r_all_ones   <= 1'b0;
            r_illegal_op <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_res        <= w_res;
                r_zero       <= (w_res == '0);
                r_all_ones   <= (w_res == '1);
                r_illegal_op <= w_illegal;
            end
        end
    end

    assign bus.res        = r_res;
    assign bus.out_valid  = r_out_valid;
    assign bus.zero       = r_zero;
    assign bus.all_ones   = r_all_ones;
    assign bus.illegal_op = r_illegal_op;

endmodule : bitwise_logic_unit
`default_nettype wire

// File: tb/tb_bitwise_logic_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitwise_logic_unit
//  Description : Self-checking bench for bitwise_logic_unit. Runs an 8-bit and
//                a 32-bit instance side by side on a shared clock/reset,
//                comparing every output each cycle against a bit-level
//                reference model, plus literal expectations for directed cases.
//                Optional feature macro: LOGIC_XOR_EN (changes op=11 results).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bitwise_logic_unit;
    import logic_unit_pkg::*;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bitwise_logic_unit_if #(.N(8))  bus8 ();
    bitwise_logic_unit_if #(.N(32)) bus32 ();

    bitwise_logic_unit #(.N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    bitwise_logic_unit #(.N(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        zero;
        logic        all;
        logic        ill;
    } mstate_t;

    mstate_t m8;
    mstate_t m32;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bit-by-bit truth from the operation's definition: count the ones in
    // (a[i], b[i]) and decide the output bit from that count.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input int w);
        logic [31:0] r;
        int          s;
        r = '0;
        for (int i = 0; i < w; i++) begin
            s = int'(a[i]) + int'(b[i]);
            case (op)
                2'd0:    r[i] = (s == 2);
                2'd1:    r[i] = (s >= 1);
                2'd2:    r[i] = (a[i] == 1'b0);
`ifdef LOGIC_XOR_EN
                default: r[i] = (s == 1);
`else
                default: r[i] = 1'b0;
`endif
            endcase
        end
        return r;
    endfunction

    function automatic mstate_t next_state(input mstate_t cur, input logic r, input logic v,
                                           input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        mstate_t     n;
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        n = cur;
        if (r) begin
            n.res = '0; n.ov = 1'b0; n.zero = 1'b1; n.all = 1'b0; n.ill = 1'b0;
        end else begin
            n.ov = v;
            if (v) begin
                n.res  = ref_result(op, a, b, w);
                n.zero = (n.res == 32'd0);
                n.all  = (n.res == mask);
`ifdef LOGIC_XOR_EN
                n.ill  = 1'b0;
`else
                n.ill  = (op == 2'd3);
`endif
            end
        end
        return n;
    endfunction

    // Advance one clock, update both models from the inputs presented during
    // the cycle, and compare every output of both instances.
    task automatic tick(input string tag);
        logic        s_rst, s_v8, s_v32;
        logic [1:0]  s_op8, s_op32;
        logic [31:0] s_a8, s_b8, s_a32, s_b32;
        s_rst  = rst;
        s_v8   = bus8.in_valid;   s_op8  = bus8.op;
        s_a8   = {24'd0, bus8.a}; s_b8   = {24'd0, bus8.b};
        s_v32  = bus32.in_valid;  s_op32 = bus32.op;
        s_a32  = bus32.a;         s_b32  = bus32.b;
        @(posedge clk);
        #1;
        m8  = next_state(m8,  s_rst, s_v8,  s_op8,  s_a8,  s_b8,  8);
        m32 = next_state(m32, s_rst, s_v32, s_op32, s_a32, s_b32, 32);
        check_eq({tag, ".res8"},   {24'd0, bus8.res},       m8.res);
        check_eq({tag, ".ov8"},    {31'd0, bus8.out_valid}, {31'd0, m8.ov});
        check_eq({tag, ".zero8"},  {31'd0, bus8.zero},      {31'd0, m8.zero});
        check_eq({tag, ".ones8"},  {31'd0, bus8.all_ones},  {31'd0, m8.all});
        check_eq({tag, ".ill8"},   {31'd0, bus8.illegal_op},{31'd0, m8.ill});
        check_eq({tag, ".res32"},  bus32.res,               m32.res);
        check_eq({tag, ".ov32"},   {31'd0, bus32.out_valid},{31'd0, m32.ov});
        check_eq({tag, ".zero32"}, {31'd0, bus32.zero},     {31'd0, m32.zero});
        check_eq({tag, ".ones32"}, {31'd0, bus32.all_ones}, {31'd0, m32.all});
        check_eq({tag, ".ill32"},  {31'd0, bus32.illegal_op},{31'd0, m32.ill});
    endtask

    task automatic drive8(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus8.in_valid = v;
        bus8.op       = op;
        bus8.a        = v ? a : 8'hxx;
        bus8.b        = v ? b : 8'hxx;
    endtask

    task automatic drive32(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.in_valid = v;
        bus32.op       = op;
        bus32.a        = v ? a : 32'hxxxx_xxxx;
        bus32.b        = v ? b : 32'hxxxx_xxxx;
    endtask

    logic [7:0] exp_xor_res;
    logic       exp_xor_ill;

    initial begin
        m8  = '{res: 32'd0, ov: 1'b0, zero: 1'b0, all: 1'b0, ill: 1'b0};
        m32 = m8;
        rst = 1'b1;
        drive8(1'b0, 2'd0, 8'h00, 8'h00);
        drive32(1'b0, 2'd0, 32'd0, 32'd0);

        // 1. reset held two cycles
        tick("rst0");
        tick("rst1");
        check_eq("rst.res8",  {24'd0, bus8.res}, 32'h0);
        check_eq("rst.zero8", {31'd0, bus8.zero}, 32'd1);
        check_eq("rst.ov32",  {31'd0, bus32.out_valid}, 32'd0);
        check_eq("rst.ill32", {31'd0, bus32.illegal_op}, 32'd0);
        rst = 1'b0;

        // 2. AND
        drive8(1'b1, OP_AND, 8'hF0, 8'h3C);
        tick("and");
        check_eq("and.res",  {24'd0, bus8.res}, 32'h30);
        check_eq("and.ov",   {31'd0, bus8.out_valid}, 32'd1);

        // 3. OR then idle hold
        drive8(1'b1, OP_OR, 8'h0F, 8'hF0);
        tick("or");
        check_eq("or.res",   {24'd0, bus8.res}, 32'hFF);
        check_eq("or.ones",  {31'd0, bus8.all_ones}, 32'd1);
        drive8(1'b0, OP_AND, 8'h00, 8'h00);
        tick("hold");
        check_eq("hold.res", {24'd0, bus8.res}, 32'hFF);
        check_eq("hold.ov",  {31'd0, bus8.out_valid}, 32'd0);

        // 4. NOT_A, b ignored
        drive8(1'b1, OP_NOT_A, 8'hFF, 8'hA5);
        tick("nota0");
        check_eq("nota0.res",  {24'd0, bus8.res}, 32'h00);
        check_eq("nota0.zero", {31'd0, bus8.zero}, 32'd1);
        drive8(1'b1, OP_NOT_A, 8'h00, 8'hA5);
        tick("nota1");
        check_eq("nota1.res",  {24'd0, bus8.res}, 32'hFF);

        // 5. op=11
`ifdef LOGIC_XOR_EN
        exp_xor_res = 8'hF0; exp_xor_ill = 1'b0;
`else
        exp_xor_res = 8'h00; exp_xor_ill = 1'b1;
`endif
        drive8(1'b1, OP_XOR, 8'h0F, 8'hFF);
        tick("op3");
        check_eq("op3.res", {24'd0, bus8.res}, {24'd0, exp_xor_res});
        check_eq("op3.ill", {31'd0, bus8.illegal_op}, {31'd0, exp_xor_ill});
        check_eq("op3.ov",  {31'd0, bus8.out_valid}, 32'd1);

        // 6. random back-to-back streams with a mid-stream reset pulse
        for (int i = 0; i < 300; i++) begin
            rst = (i == 150);
            drive32(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 2)), $urandom, $urandom);
            drive8(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   8'($urandom), 8'($urandom));
            // Occasionally force the flag boundaries on the wide instance.
            if (i % 37 == 5) drive32(1'b1, OP_NOT_A, 32'h0, $urandom);
            if (i % 41 == 7) drive32(1'b1, OP_AND, 32'h0, $urandom);
            if (i == 150) drive32(1'b1, OP_OR, 32'hFFFF_FFFF, 32'h0);
            tick("rand");
            if (i == 150) begin
                check_eq("midrst.res32", bus32.res, 32'h0);
                check_eq("midrst.ov32",  {31'd0, bus32.out_valid}, 32'd0);
            end
        end

        rst = 1'b0;
        drive8(1'b0, OP_AND, 8'h00, 8'h00);
        drive32(1'b0, OP_AND, 32'd0, 32'd0);
        tick("tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bitwise_logic_unit
`default_nettype wire
